// File: rtl/phys_reg_pkg.sv
// Shared sizing and tag/pointer types for the physical register pool.
// The free list and the physical register file both import this package.
package phys_reg_pkg;

   localparam int NUM_PHYS = 256;
   localparam int NUM_ARCH = 32;
   localparam int TAG_W    = 8;
   localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [TAG_W:0]   ptr_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side bundle of the physical register free list.
// The master side (rename/retire logic) drives requests; the slave side is the free list.
interface phys_reg_free_list_if;
   import phys_reg_pkg::*;

   logic alloc_req;
   logic alloc_ready;
   tag_t alloc_tag;
   tag_t rd_phy;
   logic commit_valid;
   logic free_valid;
   tag_t free_tag;
   logic flush;
   ptr_t free_count;
   logic overflow_err;
   logic underflow_err;

   modport master (
      output alloc_req, commit_valid, free_valid, free_tag, flush,
      input  alloc_ready, alloc_tag, rd_phy, free_count, overflow_err, underflow_err
   );

   modport slave (
      input  alloc_req, commit_valid, free_valid, free_tag, flush,
      output alloc_ready, alloc_tag, rd_phy, free_count, overflow_err, underflow_err
   );

endinterface

// File: rtl/phys_reg_free_list.sv
// Physical register free list: a circular buffer of free tags with a
// speculative head (rd_ptr), a committed head (cmt_ptr) and a tail (wr_ptr).
// Flush rewinds the speculative head to the committed head.
module phys_reg_free_list
   import phys_reg_pkg::*;
(
   input logic clk,
   input logic reset,
   phys_reg_free_list_if.slave fl
);

   tag_t mem [NUM_PHYS];
   ptr_t rd_ptr;
   ptr_t cmt_ptr;
   ptr_t wr_ptr;
   logic overflow_q;
   logic underflow_q;

   ptr_t count;
   ptr_t cmt_next;
   tag_t head_tag;
   logic ready;
   logic fire;
   logic free_ok;
   logic free_ovf;
   logic commit_ok;
   logic commit_unf;

   // Decode this cycle's allocate/free/commit events and drive the rename-side outputs.
   always_comb begin
      count      = wr_ptr - rd_ptr;
      ready      = (count != '0);
      head_tag   = mem[rd_ptr[TAG_W-1:0]];
      fire       = fl.alloc_req && ready && !fl.flush && !reset;
      free_ok    = fl.free_valid && (fl.free_tag != '0) && (count < ptr_t'(NUM_FREE));
      free_ovf   = fl.free_valid && (fl.free_tag != '0) && !(count < ptr_t'(NUM_FREE));
      commit_ok  = fl.commit_valid && (cmt_ptr != rd_ptr);
      commit_unf = fl.commit_valid && (cmt_ptr == rd_ptr);
      cmt_next   = commit_ok ? (cmt_ptr + ptr_t'(1)) : cmt_ptr;

      fl.alloc_ready   = ready;
      fl.alloc_tag     = head_tag;
      fl.rd_phy        = fire ? head_tag : '0;
      fl.free_count    = count;
      fl.overflow_err  = overflow_q;
      fl.underflow_err = underflow_q;
   end

   // Storage, pointer and sticky error state; tags NUM_ARCH.. start out free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PHYS; i++) begin
            mem[i] <= (i < NUM_FREE) ? tag_t'(NUM_ARCH + i) : '0;
         end
         rd_ptr      <= '0;
         cmt_ptr     <= '0;
         wr_ptr      <= ptr_t'(NUM_FREE);
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (free_ok) begin
            mem[wr_ptr[TAG_W-1:0]] <= fl.free_tag;
            wr_ptr                 <= wr_ptr + ptr_t'(1);
         end
         if (fl.flush) begin
            rd_ptr <= cmt_next;
         end else if (fire) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
         end
         cmt_ptr <= cmt_next;
         if (free_ovf) begin
            overflow_q <= 1'b1;
         end
         if (commit_unf) begin
            underflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the pool (committed+speculative tags in order).
module tb_phys_reg_free_list;
   import phys_reg_pkg::*;

   logic clk = 1'b0;
   logic reset;

   phys_reg_free_list_if fl_if ();

   phys_reg_free_list dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl_if)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   bit model_check = 1'b0;

   // Model: pool holds every tag from the committed head to the tail, in order.
   // The first spec_cnt entries have been handed out speculatively.
   tag_t pool [$];
   int   spec_cnt;
   bit   m_ovf;
   bit   m_unf;

   function automatic void model_reset();
      pool.delete();
      for (int i = 0; i < NUM_FREE; i++) pool.push_back(tag_t'(NUM_ARCH + i));
      spec_cnt = 0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
   endfunction

   function automatic int model_count();
      return pool.size() - spec_cnt;
   endfunction

   function automatic int model_rd_phy();
      if (fl_if.alloc_req && (model_count() > 0) && !fl_if.flush) return int'(pool[spec_cnt]);
      return 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit req, input bit cv, input bit fv, input int tag, input bit fls);
      fl_if.alloc_req    = req;
      fl_if.commit_valid = cv;
      fl_if.free_valid   = fv;
      fl_if.free_tag     = tag_t'(tag);
      fl_if.flush        = fls;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      applyStimulus(0, 0, 0, 0, 0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   // Advance the model on each clock edge using the inputs presented this cycle.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_reset();
      end else begin
         int  fc;
         bit  fire, free_ok, commit_ok;
         fc        = model_count();
         fire      = fl_if.alloc_req && (fc > 0) && !fl_if.flush;
         free_ok   = fl_if.free_valid && (fl_if.free_tag != 0) && (fc < NUM_FREE);
         commit_ok = fl_if.commit_valid && (spec_cnt > 0);
         if (fl_if.free_valid && (fl_if.free_tag != 0) && (fc >= NUM_FREE)) m_ovf = 1'b1;
         if (fl_if.commit_valid && (spec_cnt == 0)) m_unf = 1'b1;
         if (free_ok) pool.push_back(fl_if.free_tag);
         if (commit_ok) begin
            void'(pool.pop_front());
            spec_cnt--;
         end
         if (fire) spec_cnt++;
         if (fl_if.flush) spec_cnt = 0;
      end
   end

   // Every cycle out of reset, compare all outputs with the model mid-cycle.
   always @(negedge clk) begin
      if (model_check && !reset) begin
         checkOutput("m_free_count", 32'(fl_if.free_count), model_count());
         checkOutput("m_alloc_ready", 32'(fl_if.alloc_ready), (model_count() > 0) ? 1 : 0);
         checkOutput("m_rd_phy", 32'(fl_if.rd_phy), model_rd_phy());
         checkOutput("m_overflow", 32'(fl_if.overflow_err), 32'(m_ovf));
         checkOutput("m_underflow", 32'(fl_if.underflow_err), 32'(m_unf));
         if (model_count() > 0) checkOutput("m_alloc_tag", 32'(fl_if.alloc_tag), int'(pool[spec_cnt]));
      end
   end

   initial begin
      applyStimulus(0, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_check = 1'b1;

      // Reset values, then drain the whole list in order.
      $display("[TB] drain after reset");
      do_reset();
      @(negedge clk);
      checkOutput("rst_free_count", 32'(fl_if.free_count), 224);
      checkOutput("rst_alloc_ready", 32'(fl_if.alloc_ready), 1);
      checkOutput("rst_rd_phy", 32'(fl_if.rd_phy), 0);
      checkOutput("rst_overflow", 32'(fl_if.overflow_err), 0);
      checkOutput("rst_underflow", 32'(fl_if.underflow_err), 0);
      next_cycle();
      for (int i = 0; i < 224; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         @(negedge clk);
         checkOutput("drain_rd_phy", 32'(fl_if.rd_phy), 32 + i);
         next_cycle();
      end
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("empty_alloc_ready", 32'(fl_if.alloc_ready), 0);
      checkOutput("empty_free_count", 32'(fl_if.free_count), 0);
      checkOutput("empty_rd_phy", 32'(fl_if.rd_phy), 0);
      next_cycle();

      // Allocate three, commit one, flush: head rewinds to tag 33.
      $display("[TB] flush rollback");
      do_reset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         @(negedge clk);
         checkOutput("spec_rd_phy", 32'(fl_if.rd_phy), 32 + i);
         next_cycle();
      end
      applyStimulus(0, 1, 0, 0, 0);
      next_cycle();
      applyStimulus(1, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("flush_rd_phy", 32'(fl_if.rd_phy), 0);
      next_cycle();
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("post_flush_count", 32'(fl_if.free_count), 223);
      checkOutput("post_flush_rd_phy", 32'(fl_if.rd_phy), 33);
      next_cycle();

      // Empty list with a free: no bypass, tag available one cycle later.
      $display("[TB] free into empty list");
      do_reset();
      for (int i = 0; i < 224; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         next_cycle();
      end
      applyStimulus(1, 0, 1, 7, 0);
      @(negedge clk);
      checkOutput("nobypass_ready", 32'(fl_if.alloc_ready), 0);
      checkOutput("nobypass_rd_phy", 32'(fl_if.rd_phy), 0);
      next_cycle();
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("refill_ready", 32'(fl_if.alloc_ready), 1);
      checkOutput("refill_rd_phy", 32'(fl_if.rd_phy), 7);
      next_cycle();

      // Free into a full list: dropped and sticky error; tag 0 is a no-op.
      $display("[TB] overflow");
      do_reset();
      applyStimulus(0, 0, 1, 40, 0);
      @(negedge clk);
      checkOutput("ovf_before", 32'(fl_if.overflow_err), 0);
      next_cycle();
      applyStimulus(0, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("ovf_set", 32'(fl_if.overflow_err), 1);
      checkOutput("ovf_count", 32'(fl_if.free_count), 224);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0);
      repeat (3) next_cycle();
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("ovf_sticky", 32'(fl_if.overflow_err), 1);
      checkOutput("ovf_zero_tag_count", 32'(fl_if.free_count), 224);
      checkOutput("ovf_rd_phy", 32'(fl_if.rd_phy), 32);
      next_cycle();

      // Commit with nothing outstanding: underflow, committed head unmoved.
      $display("[TB] underflow");
      do_reset();
      applyStimulus(0, 1, 0, 0, 0);
      @(negedge clk);
      checkOutput("unf_before", 32'(fl_if.underflow_err), 0);
      next_cycle();
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("unf_set", 32'(fl_if.underflow_err), 1);
      checkOutput("unf_rd_phy", 32'(fl_if.rd_phy), 32);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 1);
      next_cycle();
      applyStimulus(1, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("unf_cmt_kept", 32'(fl_if.rd_phy), 32);
      checkOutput("unf_count", 32'(fl_if.free_count), 224);
      next_cycle();

      // Asynchronous reset in the middle of an allocate/free burst.
      $display("[TB] reset mid-burst");
      do_reset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 1, 100 + i, 0);
         next_cycle();
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_free_count", 32'(fl_if.free_count), 224);
      checkOutput("arst_alloc_ready", 32'(fl_if.alloc_ready), 1);
      checkOutput("arst_rd_phy", 32'(fl_if.rd_phy), 0);
      checkOutput("arst_alloc_tag", 32'(fl_if.alloc_tag), 32);
      checkOutput("arst_overflow", 32'(fl_if.overflow_err), 0);
      checkOutput("arst_underflow", 32'(fl_if.underflow_err), 0);
      next_cycle();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      next_cycle();

      // Randomized traffic against the model.
      $display("[TB] random traffic");
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit req, cv, fv, fls;
         int tag;
         req = ($urandom_range(0, 99) < 60);
         cv  = (spec_cnt > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
         fv  = (pool.size() < 240) && ($urandom_range(0, 99) < 45);
         tag = ($urandom_range(0, 99) < 10) ? 0 : int'($urandom_range(1, 255));
         fls = ($urandom_range(0, 99) < 3);
         applyStimulus(req, cv, fv, tag, fls);
         next_cycle();
      end
      applyStimulus(0, 0, 0, 0, 0);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
